// File: rtl/arb_defs.sv
// Shared definitions for the round-robin select arbiter and its picker.
package arb_defs;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        return NUM_REQ'(1) << s;
    endfunction

endpackage

// File: rtl/rr_sel_arbiter4_pick.sv
// Round-robin winner picker: first set request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import arb_defs::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     off;

    always_comb begin
        dbl = {req, req};
        // rot[j] is the request that sits j places after ptr
        rot = dbl[ptr +: NUM_REQ];
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        any = |req;
        idx = ptr + off;
    end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// Round-robin arbiter producing a held 2-bit select for the downstream 4:1 bit mux.
module rr_sel_arbiter4
    import arb_defs::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ack,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid,
    output logic               timeout_err,
    output logic               busy
);

    logic [0:0]       state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            sel         <= '0;
            grant       <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        sel   <= pick_idx;
                        grant <= sel_onehot(pick_idx);
                        cnt   <= '0;
                        state <= ST_GRANT;
                    end
                end
                default: begin
                    // Exit priority: ack, then withdraw, then timeout; sel is left as-is
                    if (ack) begin
                        grant <= '0;
                        ptr   <= sel + SEL_W'(1);
                        state <= ST_IDLE;
                    end else if (!req[sel]) begin
                        grant <= '0;
                        state <= ST_IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        grant       <= '0;
                        ptr         <= sel + SEL_W'(1);
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign valid = (state == ST_GRANT);
    assign busy  = (state == ST_GRANT);

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Bench for rr_sel_arbiter4: vector table plus hand-written timeout and reset sequences.
module tb_rr_sel_arbiter4;

    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [3:0] req;
        logic       ack;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
    } vec_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
        logic       terr;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       ack = 1'b0;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       timeout_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    rr_sel_arbiter4 #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .ack         (ack),
        .sel         (sel),
        .grant       (grant),
        .valid       (valid),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    task automatic check_out(input string name, input exp_t e);
        exp_t a;
        a = '{sel: sel, grant: grant, valid: valid, terr: timeout_err, busy: busy};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got sel=%0d grant=%b valid=%b terr=%b busy=%b, expected sel=%0d grant=%b valid=%b terr=%b busy=%b",
                     name, a.sel, a.grant, a.valid, a.terr, a.busy,
                     e.sel, e.grant, e.valid, e.terr, e.busy);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic a, input logic [1:0] es,
                        input logic [3:0] eg, input logic ev, input logic et, input string name);
        @(negedge clk);
        req = r;
        ack = a;
        sb.push_back('{sel: es, grant: eg, valid: ev, terr: et, busy: ev});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check_out(name, sb.pop_front());
        end
    endtask

    task automatic add(input logic [3:0] r, input logic a, input logic [1:0] s,
                       input logic [3:0] g, input logic v);
        vecs.push_back('{req: r, ack: a, sel: s, grant: g, valid: v});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // rotation with all requesting
        add(4'b1111, 0, 0, 4'b0001, 1); add(4'b1111, 1, 0, 4'b0000, 0);
        add(4'b1111, 0, 1, 4'b0010, 1); add(4'b1111, 1, 1, 4'b0000, 0);
        add(4'b1111, 0, 2, 4'b0100, 1); add(4'b1111, 1, 2, 4'b0000, 0);
        add(4'b1111, 0, 3, 4'b1000, 1); add(4'b1111, 1, 3, 4'b0000, 0);
        add(4'b1111, 0, 0, 4'b0001, 1); add(4'b1111, 1, 0, 4'b0000, 0);
        // pointer priority
        add(4'b0010, 0, 1, 4'b0010, 1); add(4'b0010, 1, 1, 4'b0000, 0);
        add(4'b0011, 0, 0, 4'b0001, 1); add(4'b0011, 1, 0, 4'b0000, 0);
        add(4'b0011, 0, 1, 4'b0010, 1); add(4'b0011, 1, 1, 4'b0000, 0);
        // withdraw keeps pointer
        add(4'b1000, 0, 3, 4'b1000, 1); add(4'b0000, 0, 3, 4'b0000, 0);
        add(4'b1001, 0, 3, 4'b1000, 1); add(4'b1001, 1, 3, 4'b0000, 0);
        // ack in idle ignored, req changes during grant ignored
        add(4'b0000, 1, 3, 4'b0000, 0);
        add(4'b0100, 0, 2, 4'b0100, 1); add(4'b0110, 0, 2, 4'b0100, 1);
        add(4'b0111, 1, 2, 4'b0000, 0);
        // ack together with withdraw is a normal release
        add(4'b0001, 0, 0, 4'b0001, 1); add(4'b0000, 1, 0, 4'b0000, 0);
        add(4'b1011, 0, 1, 4'b0010, 1); add(4'b1011, 1, 1, 4'b0000, 0);

        #2;
        check_out("reset_state", '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req, vecs[i].ack, vecs[i].sel, vecs[i].grant, vecs[i].valid, 1'b0,
                 $sformatf("vec%0d", i));
        end

        // timeout: ptr=2, req[2] held with no ack
        for (int i = 1; i <= TIMEOUT; i++) begin
            step(4'b0100, 0, 2, 4'b0100, 1, 0, $sformatf("timeout_hold%0d", i));
        end
        step(4'b0100, 0, 2, 4'b0000, 0, 1, "timeout_release");
        step(4'b1100, 0, 3, 4'b1000, 1, 0, "timeout_next_scan");
        step(4'b1100, 1, 3, 4'b0000, 0, 0, "timeout_next_ack");

        // ack on the last allowed grant cycle: normal release
        for (int i = 1; i <= TIMEOUT; i++) begin
            step(4'b0001, 0, 0, 4'b0001, 1, 0, $sformatf("ackto_hold%0d", i));
        end
        step(4'b0001, 1, 0, 4'b0000, 0, 0, "ackto_release");
        step(4'b0000, 0, 0, 4'b0000, 0, 0, "ackto_no_err");
        step(4'b0011, 0, 1, 4'b0010, 1, 0, "ackto_ptr_adv");
        step(4'b0011, 1, 1, 4'b0000, 0, 0, "ackto_ptr_ack");

        // reset in the middle of a grant on sel=2
        step(4'b0100, 0, 2, 4'b0100, 1, 0, "pre_reset_grant");
        #3;
        rst_n = 1'b0;
        #1;
        check_out("reset_mid_grant", '0);
        @(negedge clk);
        req = 4'b0000;
        rst_n = 1'b1;
        step(4'b0000, 0, 0, 4'b0000, 0, 0, "post_reset_idle");
        step(4'b0001, 0, 0, 4'b0001, 1, 0, "post_reset_grant");
        step(4'b0001, 1, 0, 4'b0000, 0, 0, "post_reset_ack");
        step(4'b1010, 0, 1, 4'b0010, 1, 0, "post_reset_ptr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_sel_arbiter4.md
Name: rr_sel_arbiter4

Overview:
- Round-robin arbiter that generates the 2-bit select driving the team's 4:1 bit multiplexer; sits directly upstream of it.
- Four requesters raise req. The arbiter picks one and presents the matching sel, grant and valid to the consumer.
- It holds the selection until the consumer acks, the requester withdraws, or a hold timeout expires.
- Guarantees a stable sel for the whole mux transaction and fair access across the four inputs.

Parameters:
- TIMEOUT, 15, maximum GRANT cycles without ack before forced release; legal range 2..255.
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  4  request per mux input; req[i] pairs with mux data bit i.
- ack  input  1  consumer has sampled the mux output for the current grant.
- sel  output  2  mux select (registered); index of granted requester.
- grant  output  4  one-hot grant (registered); all-zero when idle.
- valid  output  1  high while a grant is active; sel is stable while valid=1.
- timeout_err  output  1  one-cycle pulse when a grant is force-released.
- busy  output  1  equals state==GRANT.

Behaviour:
- Reset (rst_n=0, async):
  - sel=2'b00, grant=4'b0000, valid=0, timeout_err=0, busy=0.
  - Internal: ptr=2'b00, cnt=0, state=IDLE.
  - Deassertion takes effect on the next rising edge. Reset mid-GRANT drops the grant immediately, with no timeout_err.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0: pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: sel=winner, grant=1<<winner, valid=1, cnt=0, state=GRANT.
  - Latency is one cycle from req sampled to valid high.
  - If req==0: remain in IDLE; sel holds its last value.
  - ack in IDLE is ignored.
- GRANT, exits evaluated each edge in this priority order:
  1. ack=1: normal release. grant=0, valid=0, ptr=sel+1 (wraps 3->0), state=IDLE.
  2. req[sel]=0: withdraw. Release as above, ptr unchanged, no error.
  3. cnt==TIMEOUT-1: forced release. Release with ptr=sel+1 and timeout_err=1 for exactly one cycle.
  4. Otherwise: cnt=cnt+1, all outputs held.
- Simultaneous events: ack together with a withdraw or timeout is a normal release, no error.
- Throughput: at least one bubble cycle (IDLE) between grants, so the maximum rate is one grant per 2 cycles.
- Ack on the first GRANT cycle is legal; the grant lasts 1 cycle.
- sel is never changed while valid=1. sel keeps its last value after release so the mux output stays quiet.
- grant always equals (valid ? 1<<sel : 0).
- Fairness: a continuously requesting input waits at most 3 other grants.
- Changes to req during GRANT have no effect except for the withdraw rule.

Decomposition:
- Shared package/header (arb_defs): state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1, NUM_REQ=4, SEL_W=2.
- Sub-module rr_pick4 (combinational): inputs req[3:0], ptr[1:0]; outputs any, idx[1:0]. Implements the rotate, priority-encode and un-rotate. It is instantiated once.
- The top holds the FSM, counter, pointer and output registers.

Test Plan:
- Reset: assert rst_n=0 mid-GRANT with sel=2 -> same cycle grant=0000, valid=0, sel=00. After release, req=0001 -> grant=0001, sel=00 one cycle later.
- Rotation: req=1111 held, ack one cycle after each valid -> sel sequence 0,1,2,3,0 with a 1-cycle IDLE gap between grants.
- Priority from pointer: grant idx 1 acked (ptr=2), then req=0011 -> sel=0 (scan 2,3,0). Next req=0011 again after ack -> sel=1.
- Withdraw: granted sel=3, drop req[3] with no ack -> valid=0 next edge, timeout_err stays 0, ptr unchanged. req=1001 -> sel=3 granted again.
- Timeout: TIMEOUT=15, req=0100, never ack -> valid high exactly 15 cycles, timeout_err=1 for one cycle at release, next winner scan starts at 3.
- Ack and timeout same cycle: ack asserted on the 15th GRANT cycle -> normal release, timeout_err=0.
